lsu_dmem_ctrl: RTL and testbench

//  Load/store initiator between the core's execute stage and the word-wide data RAM.

---
 rtl/lsu_dmem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_ctrl.sv
// rtl/lsu_dmem_ctrl.sv - load/store controller for a word-wide data RAM with sub-word extract and merge
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses complete with rsp_err_o instead of being force-aligned.
module lsu_dmem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_wr_en_o,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_w_data_o,
    input  logic [31:0]       mem_r_data_i
);
    localparam int AW = ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   word_q, word_d;

    logic          req_illegal;
    logic          req_misaligned;
    logic          unused_addr_hi;
    logic [4:0]    byte_sh;
    logic [4:0]    half_sh;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   merged;

    // Byte address bits above the RAM size wrap around.
    assign unused_addr_hi = ^req_addr_i[31:AW];

    always_comb begin
        if (req_we_i) begin
            req_illegal = !(req_funct3_i inside {3'b000, 3'b001, 3'b010});
        end else begin
            req_illegal = !(req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        req_misaligned = 1'b0;
        if (req_funct3_i[1:0] == 2'b01) begin
            req_misaligned = req_addr_i[0];
        end else if (req_funct3_i[1:0] == 2'b10) begin
            req_misaligned = |req_addr_i[1:0];
        end
    end
`else
    assign req_misaligned = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d   = req_addr_i[AW-1:0];
                    funct3_d = req_funct3_i;
                    we_d     = req_we_i;
                    wdata_d  = req_wdata_i;
                    err_d    = req_illegal || req_misaligned;
                    if (req_illegal || req_misaligned) begin
                        state_d = S_RSP;
                    end else if (req_we_i && req_funct3_i == 3'b010) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            // Sub-word stores also pass through here to fetch the word they merge into.
            S_RD: begin
                word_d  = mem_r_data_i;
                state_d = we_q ? S_WR : S_RSP;
            end
            S_WR:    state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RSP);
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign mem_rd_en_o = (state_q == S_RD);
    assign mem_wr_en_o = (state_q == S_WR);
    assign mem_addr_o  = addr_q[AW-1:2];

    assign byte_sh = {addr_q[1:0], 3'b000};
    assign half_sh = {addr_q[1], 4'b0000};
    assign ld_byte = word_q[byte_sh +: 8];
    assign ld_half = word_q[half_sh +: 16];

    always_comb begin
        rsp_rdata_o = '0;
        if (rsp_valid_o && !we_q && !err_q) begin
            case (funct3_q)
                3'b000:  rsp_rdata_o = {{24{ld_byte[7]}}, ld_byte};
                3'b001:  rsp_rdata_o = {{16{ld_half[15]}}, ld_half};
                3'b010:  rsp_rdata_o = word_q;
                3'b100:  rsp_rdata_o = {24'h0, ld_byte};
                3'b101:  rsp_rdata_o = {16'h0, ld_half};
                default: rsp_rdata_o = '0;
            endcase
        end
    end

    always_comb begin
        merged = word_q;
        case (funct3_q[1:0])
            2'b00:   merged[byte_sh +: 8]  = wdata_q[7:0];
            2'b01:   merged[half_sh +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
        mem_w_data_o = mem_wr_en_o ? merged : 32'h0;
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb/tb_lsu_dmem_ctrl.sv - table-driven bench for lsu_dmem_ctrl with a behavioural word RAM
module tb_lsu_dmem_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    logic [31:0] ram [256];

    int n_cmp;
    int n_fail;

    lsu_dmem_ctrl #(.ADDR_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem_wr_en_o  (mem_wr_en),
        .mem_rd_en_o  (mem_rd_en),
        .mem_addr_o   (mem_addr),
        .mem_w_data_o (mem_w_data),
        .mem_r_data_i (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_w_data;
    end
    assign mem_r_data = ram[mem_addr];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic        chk_ram;
        int          ram_idx;
        logic [31:0] ram_val;
    } vec_t;

    localparam int NV = 21;
    vec_t vec [NV];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] er, logic ee, int lat, int rd, int wr,
                                logic cr, int ri, logic [31:0] rv);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr;
        v.chk_ram = cr; v.ram_idx = ri; v.ram_val = rv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, output logic [31:0] rdata, output logic err,
                          output int lat, output int rdc, output int wrc, output logic busy_ok);
        rdata = 32'h0; err = 1'b0; lat = 0; rdc = 0; wrc = 0; busy_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_rd_en) rdc++;
            if (mem_wr_en) wrc++;
            if (mem_rd_en && mem_wr_en) wrc += 100;
            if (req_ready) busy_ok = 1'b0;
            if (rsp_valid) begin
                lat = k; rdata = rsp_rdata; err = rsp_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic        busy_ok;
        logic        seen;
        int          lat, rdc, wrc;
        logic [6:0]  rv_bits, rdy_bits;
        logic [31:0] b2b_data [2];
        int          b2b_n;

        n_cmp = 0; n_fail = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[4] = 32'h8081_7F80;
        ram[8] = 32'h5566_7788;

        vec[0]  = mk(0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FF80, 0, 2, 1, 0, 0, 0, 0);
        vec[1]  = mk(0, 3'b100, 32'h10, 32'h0, 32'h0000_0080, 0, 2, 1, 0, 0, 0, 0);
        vec[2]  = mk(0, 3'b000, 32'h11, 32'h0, 32'h0000_007F, 0, 2, 1, 0, 0, 0, 0);
        vec[3]  = mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8081, 0, 2, 1, 0, 0, 0, 0);
        vec[4]  = mk(0, 3'b010, 32'h10, 32'h0, 32'h8081_7F80, 0, 2, 1, 0, 0, 0, 0);
        vec[5]  = mk(0, 3'b101, 32'h12, 32'h0, 32'h0000_8081, 0, 2, 1, 0, 0, 0, 0);
        vec[6]  = mk(0, 3'b000, 32'h12, 32'h0, 32'hFFFF_FF81, 0, 2, 1, 0, 0, 0, 0);
        vec[7]  = mk(0, 3'b100, 32'h13, 32'h0, 32'h0000_0080, 0, 2, 1, 0, 0, 0, 0);
        vec[8]  = mk(0, 3'b001, 32'h10, 32'h0, 32'h0000_7F80, 0, 2, 1, 0, 0, 0, 0);
        vec[9]  = mk(1, 3'b000, 32'h13, 32'h1234_56AA, 32'h0, 0, 3, 1, 1, 1, 4, 32'hAA81_7F80);
        vec[10] = mk(1, 3'b001, 32'h10, 32'h5555_BEEF, 32'h0, 0, 3, 1, 1, 1, 4, 32'hAA81_BEEF);
        vec[11] = mk(1, 3'b010, 32'h3FC, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1, 1, 255, 32'hDEAD_BEEF);
        vec[12] = mk(1, 3'b010, 32'h400, 32'h1122_3344, 32'h0, 0, 2, 0, 1, 1, 0, 32'h1122_3344);
        vec[13] = mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        vec[14] = mk(1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 1, 4, 32'hAA81_BEEF);
`ifdef MISALIGN_TRAP_EN
        vec[15] = mk(0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        vec[16] = mk(0, 3'b001, 32'h11, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        vec[17] = mk(1, 3'b010, 32'h2E, 32'hCAFE_F00D, 32'h0, 1, 1, 0, 0, 1, 11, 32'h0);
        vec[18] = mk(0, 3'b101, 32'h13, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
`else
        vec[15] = mk(0, 3'b010, 32'h12, 32'h0, 32'hAA81_BEEF, 0, 2, 1, 0, 0, 0, 0);
        vec[16] = mk(0, 3'b001, 32'h11, 32'h0, 32'hFFFF_BEEF, 0, 2, 1, 0, 0, 0, 0);
        vec[17] = mk(1, 3'b010, 32'h2E, 32'hCAFE_F00D, 32'h0, 0, 2, 0, 1, 1, 11, 32'hCAFE_F00D);
        vec[18] = mk(0, 3'b101, 32'h13, 32'h0, 32'h0000_AA81, 0, 2, 1, 0, 0, 0, 0);
`endif
        vec[19] = mk(1, 3'b000, 32'h11, 32'h0000_0077, 32'h0, 0, 3, 1, 1, 1, 4, 32'hAA81_77EF);
        vec[20] = mk(0, 3'b010, 32'h410, 32'h0, 32'hAA81_77EF, 0, 2, 1, 0, 0, 0, 0);

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready",  32'(req_ready),  32'h1);
        check("rst_rspv",   32'(rsp_valid),  32'h0);
        check("rst_err",    32'(rsp_err),    32'h0);
        check("rst_rdata",  rsp_rdata,       32'h0);
        check("rst_wr_en",  32'(mem_wr_en),  32'h0);
        check("rst_rd_en",  32'(mem_rd_en),  32'h0);
        check("rst_addr",   32'(mem_addr),   32'h0);
        check("rst_wdata",  mem_w_data,      32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < NV; i++) begin
            run_op(vec[i], rdata, err, lat, rdc, wrc, busy_ok);
            check($sformatf("v%0d_lat", i),   32'(lat), 32'(vec[i].exp_lat));
            check($sformatf("v%0d_err", i),   32'(err), 32'(vec[i].exp_err));
            check($sformatf("v%0d_rdata", i), rdata,    vec[i].exp_rdata);
            check($sformatf("v%0d_rdcnt", i), 32'(rdc), 32'(vec[i].exp_rd));
            check($sformatf("v%0d_wrcnt", i), 32'(wrc), 32'(vec[i].exp_wr));
            check($sformatf("v%0d_busy_ready", i), 32'(busy_ok), 32'h1);
            if (vec[i].chk_ram) check($sformatf("v%0d_ram", i), ram[vec[i].ram_idx], vec[i].ram_val);
        end

        // Back-to-back LW with req_valid held high.
        rv_bits = '0; rdy_bits = '0; b2b_n = 0;
        b2b_data[0] = 32'h0; b2b_data[1] = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rv_bits[k]  = rsp_valid;
            rdy_bits[k] = req_ready;
            if (rsp_valid && b2b_n < 2) begin
                b2b_data[b2b_n] = rsp_rdata;
                b2b_n++;
            end
            if (k == 5) req_valid = 1'b0;
        end
        check("b2b_rsp_valid_pattern", 32'(rv_bits),  32'h24);
        check("b2b_ready_pattern",     32'(rdy_bits), 32'h48);
        check("b2b_data0", b2b_data[0], 32'hAA81_77EF);
        check("b2b_data1", b2b_data[1], 32'hAA81_77EF);

        // Reset asserted while an SB is in its write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h0000_00FF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wr", 32'(mem_wr_en), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_wr_en",  32'(mem_wr_en), 32'h0);
        check("abort_ready",  32'(req_ready), 32'h1);
        check("abort_rspv",   32'(rsp_valid), 32'h0);
        check("abort_addr",   32'(mem_addr),  32'h0);
        check("abort_wdata",  mem_w_data,     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'h0);
        check("abort_ram_unchanged", ram[8], 32'h5566_7788);
        run_op(mk(0, 3'b010, 32'h20, 32'h0, 32'h0, 0, 2, 1, 0, 0, 0, 0), rdata, err, lat, rdc, wrc, busy_ok);
        check("recover_lat",   32'(lat), 32'h2);
        check("recover_rdata", rdata,    32'h5566_7788);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
